// File: rtl/mem_stage.sv
// Memory-access stage: serialises the Load/Store ops of a dual-lane bundle onto one
// single-ported data BRAM (upper lane first) and hands the packed load data to writeback.
module mem_stage #(
   parameter int ADDR_W  = 17,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              interlock,
   input  logic [31:0]       pc_from_exec,
   input  logic [63:0]       inst_from_exec,
   input  logic [31:0]       u_addr_from_exec,
   input  logic [31:0]       l_addr_from_exec,
   input  logic [31:0]       u_sdata_from_exec,
   input  logic [31:0]       l_sdata_from_exec,
   input  logic [4:0]        u_rt_from_exec,
   input  logic [4:0]        l_rt_from_exec,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output logic              stall_req,
   output logic [31:0]       pc_to_wb,
   output logic [63:0]       inst_to_wb,
   output logic [4:0]        u_rt_to_wb,
   output logic [4:0]        l_rt_to_wb,
   output logic [63:0]       mem_doutb
);

   localparam logic [5:0] OP_LOAD  = 6'h23;
   localparam logic [5:0] OP_STORE = 6'h2B;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE_U = 3'd1;
   localparam logic [2:0] S_ISSUE_L = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [1:0] LAT = 2'(RAM_LAT);

   logic [2:0]        state_reg, state_next;
   logic [31:0]       pc_reg;
   logic [63:0]       inst_reg;
   logic [ADDR_W-1:0] u_addr_reg, l_addr_reg;
   logic [31:0]       u_sdata_reg, l_sdata_reg;
   logic [4:0]        u_rt_reg, l_rt_reg;
   logic [63:0]       data_reg;
   logic [1:0]        wait_cnt_reg;
   // Per stage: {load issued, upper lane}; stage RAM_LAT lines up with valid ram_dout.
   logic [2*RAM_LAT+1:0] tag_pipe_reg;

   logic [63:0]       cur_inst;
   logic [ADDR_W-1:0] cur_u_addr, cur_l_addr;
   logic [31:0]       cur_u_sdata, cur_l_sdata;
   logic [5:0]        u_op, l_op;
   logic              u_mem, l_mem, accept, finish;
   logic              issue_u, issue_l, req_we, req_load;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_din;
   logic              cap_valid, cap_upper;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{u_addr_from_exec[31:ADDR_W], l_addr_from_exec[31:ADDR_W]};

   // In IDLE the decision is made on the incoming bundle, afterwards on the latched copy.
   always_comb begin
      cur_inst    = inst_reg;
      cur_u_addr  = u_addr_reg;
      cur_l_addr  = l_addr_reg;
      cur_u_sdata = u_sdata_reg;
      cur_l_sdata = l_sdata_reg;
      if (state_reg == S_IDLE) begin
         cur_inst    = inst_from_exec;
         cur_u_addr  = u_addr_from_exec[ADDR_W-1:0];
         cur_l_addr  = l_addr_from_exec[ADDR_W-1:0];
         cur_u_sdata = u_sdata_from_exec;
         cur_l_sdata = l_sdata_from_exec;
      end
      u_op   = cur_inst[63:58];
      l_op   = cur_inst[31:26];
      u_mem  = (u_op == OP_LOAD) || (u_op == OP_STORE);
      l_mem  = (l_op == OP_LOAD) || (l_op == OP_STORE);
      accept = (state_reg == S_IDLE) && !interlock;
      finish = !interlock && (((state_reg == S_WAIT) && (wait_cnt_reg == LAT)) ||
                              (state_reg == S_DONE));

      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (accept && (u_mem || l_mem)) state_next = u_mem ? S_ISSUE_U : S_ISSUE_L;
         S_ISSUE_U: state_next = l_mem ? S_ISSUE_L : S_WAIT;
         S_ISSUE_L: state_next = S_WAIT;
         S_WAIT:    if (wait_cnt_reg == LAT) state_next = interlock ? S_DONE : S_IDLE;
         S_DONE:    if (!interlock) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase

      issue_u  = (state_next == S_ISSUE_U);
      issue_l  = (state_next == S_ISSUE_L);
      req_we   = issue_u ? (u_op == OP_STORE) : (issue_l && (l_op == OP_STORE));
      req_addr = issue_u ? cur_u_addr : cur_l_addr;
      req_din  = issue_u ? cur_u_sdata : cur_l_sdata;
      req_load = (issue_u || issue_l) && !req_we;
   end

   assign cap_valid = tag_pipe_reg[2*RAM_LAT+1];
   assign cap_upper = tag_pipe_reg[2*RAM_LAT];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= S_IDLE;
         wait_cnt_reg <= '0;
         tag_pipe_reg <= '0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_din      <= '0;
      end else begin
         state_reg    <= state_next;
         tag_pipe_reg <= {tag_pipe_reg[2*RAM_LAT-1:0], req_load, issue_u};
         ram_en       <= issue_u || issue_l;
         ram_we       <= req_we;
         ram_addr     <= req_addr;
         ram_din      <= req_din;
         if (state_reg != S_WAIT)
            wait_cnt_reg <= '0;
         else if (wait_cnt_reg != LAT)
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_reg      <= '0;
         inst_reg    <= '0;
         u_addr_reg  <= '0;
         l_addr_reg  <= '0;
         u_sdata_reg <= '0;
         l_sdata_reg <= '0;
         u_rt_reg    <= '0;
         l_rt_reg    <= '0;
         data_reg    <= '0;
      end else begin
         if (accept && (u_mem || l_mem)) begin
            pc_reg      <= pc_from_exec;
            inst_reg    <= inst_from_exec;
            u_addr_reg  <= u_addr_from_exec[ADDR_W-1:0];
            l_addr_reg  <= l_addr_from_exec[ADDR_W-1:0];
            u_sdata_reg <= u_sdata_from_exec;
            l_sdata_reg <= l_sdata_from_exec;
            u_rt_reg    <= u_rt_from_exec;
            l_rt_reg    <= l_rt_from_exec;
            data_reg    <= '0;
         end else if (cap_valid) begin
            if (cap_upper) data_reg[63:32] <= ram_dout;
            else           data_reg[31:0]  <= ram_dout;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_req  <= 1'b0;
         pc_to_wb   <= '0;
         inst_to_wb <= '0;
         u_rt_to_wb <= '0;
         l_rt_to_wb <= '0;
         mem_doutb  <= '0;
      end else if (accept) begin
         // A bundle with memory work leaves a bubble behind it until it completes.
         stall_req  <= u_mem || l_mem;
         pc_to_wb   <= (u_mem || l_mem) ? 32'd0 : pc_from_exec;
         inst_to_wb <= (u_mem || l_mem) ? 64'd0 : inst_from_exec;
         u_rt_to_wb <= (u_mem || l_mem) ? 5'd0  : u_rt_from_exec;
         l_rt_to_wb <= (u_mem || l_mem) ? 5'd0  : l_rt_from_exec;
         mem_doutb  <= '0;
      end else if (finish) begin
         stall_req  <= 1'b0;
         pc_to_wb   <= pc_reg;
         inst_to_wb <= inst_reg;
         u_rt_to_wb <= u_rt_reg;
         l_rt_to_wb <= l_rt_reg;
         mem_doutb  <= data_reg;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with RAM_LAT=1 and one with RAM_LAT=2,
// each backed by a simple BRAM model; expected values are hand-computed.
module tb_mem_stage;

   localparam logic [63:0] ADD_INST = 64'h00221820_00432020;

   logic        clk = 1'b0;
   logic        rstn;
   logic        interlock;
   logic [31:0] pc_from_exec;
   logic [63:0] inst_from_exec;
   logic [31:0] u_addr_from_exec, l_addr_from_exec;
   logic [31:0] u_sdata_from_exec, l_sdata_from_exec;
   logic [4:0]  u_rt_from_exec, l_rt_from_exec;

   logic        ram_en_1, ram_we_1, stall_req_1;
   logic [16:0] ram_addr_1;
   logic [31:0] ram_din_1, ram_dout_1, pc_to_wb_1;
   logic [63:0] inst_to_wb_1, mem_doutb_1;
   logic [4:0]  u_rt_to_wb_1, l_rt_to_wb_1;

   logic        ram_en_2, ram_we_2, stall_req_2;
   logic [16:0] ram_addr_2;
   logic [31:0] ram_din_2, ram_dout_2, pc_to_wb_2;
   logic [63:0] inst_to_wb_2, mem_doutb_2;
   logic [4:0]  u_rt_to_wb_2, l_rt_to_wb_2;

   logic        pre_we, pre_sel;
   logic [16:0] pre_addr;
   logic [31:0] pre_data;

   logic [31:0] mem1 [0:131071];
   logic [31:0] mem2 [0:131071];
   logic [31:0] rd1_a, rd2_a, rd2_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(17), .RAM_LAT(1)) dut1 (
      .clk(clk), .rstn(rstn), .interlock(interlock),
      .pc_from_exec(pc_from_exec), .inst_from_exec(inst_from_exec),
      .u_addr_from_exec(u_addr_from_exec), .l_addr_from_exec(l_addr_from_exec),
      .u_sdata_from_exec(u_sdata_from_exec), .l_sdata_from_exec(l_sdata_from_exec),
      .u_rt_from_exec(u_rt_from_exec), .l_rt_from_exec(l_rt_from_exec),
      .ram_en(ram_en_1), .ram_we(ram_we_1), .ram_addr(ram_addr_1), .ram_din(ram_din_1),
      .ram_dout(ram_dout_1), .stall_req(stall_req_1), .pc_to_wb(pc_to_wb_1),
      .inst_to_wb(inst_to_wb_1), .u_rt_to_wb(u_rt_to_wb_1), .l_rt_to_wb(l_rt_to_wb_1),
      .mem_doutb(mem_doutb_1));

   mem_stage #(.ADDR_W(17), .RAM_LAT(2)) dut2 (
      .clk(clk), .rstn(rstn), .interlock(interlock),
      .pc_from_exec(pc_from_exec), .inst_from_exec(inst_from_exec),
      .u_addr_from_exec(u_addr_from_exec), .l_addr_from_exec(l_addr_from_exec),
      .u_sdata_from_exec(u_sdata_from_exec), .l_sdata_from_exec(l_sdata_from_exec),
      .u_rt_from_exec(u_rt_from_exec), .l_rt_from_exec(l_rt_from_exec),
      .ram_en(ram_en_2), .ram_we(ram_we_2), .ram_addr(ram_addr_2), .ram_din(ram_din_2),
      .ram_dout(ram_dout_2), .stall_req(stall_req_2), .pc_to_wb(pc_to_wb_2),
      .inst_to_wb(inst_to_wb_2), .u_rt_to_wb(u_rt_to_wb_2), .l_rt_to_wb(l_rt_to_wb_2),
      .mem_doutb(mem_doutb_2));

   always @(posedge clk) begin
      if (pre_we && !pre_sel) mem1[pre_addr] <= pre_data;
      if (ram_en_1) begin
         if (ram_we_1) mem1[ram_addr_1] <= ram_din_1;
         rd1_a <= mem1[ram_addr_1];
      end
   end
   assign ram_dout_1 = rd1_a;

   always @(posedge clk) begin
      if (pre_we && pre_sel) mem2[pre_addr] <= pre_data;
      if (ram_en_2) begin
         if (ram_we_2) mem2[ram_addr_2] <= ram_din_2;
         rd2_a <= mem2[ram_addr_2];
      end
      rd2_b <= rd2_a;
   end
   assign ram_dout_2 = rd2_b;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_bundle(input logic [31:0] pc, input logic [63:0] inst,
                             input logic [31:0] ua, input logic [31:0] la,
                             input logic [31:0] us, input logic [31:0] ls,
                             input logic [4:0] urt, input logic [4:0] lrt);
      pc_from_exec      = pc;
      inst_from_exec    = inst;
      u_addr_from_exec  = ua;
      l_addr_from_exec  = la;
      u_sdata_from_exec = us;
      l_sdata_from_exec = ls;
      u_rt_from_exec    = urt;
      l_rt_from_exec    = lrt;
   endtask

   task automatic bubble();
      set_bundle(32'd0, 64'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
   endtask

   task automatic preload(input logic sel, input logic [16:0] a, input logic [31:0] d);
      pre_sel  = sel;
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      step();
      pre_we   = 1'b0;
   endtask

   task automatic idle(input int n);
      bubble();
      for (int i = 0; i < n; i++) step();
   endtask

   // Upper Load from address 5, lower non-mem; completes three edges after accept.
   task automatic load5_sequence(input string tag);
      set_bundle(32'h40, {32'h8C090005, 32'h00432020}, 32'd5, 32'd0, 32'd0, 32'd0, 5'd9, 5'd3);
      step();
      check({tag, "_e0_stall"}, 64'(stall_req_1), 64'd1);
      check({tag, "_e0_ram_en"}, 64'(ram_en_1), 64'd1);
      check({tag, "_e0_ram_we"}, 64'(ram_we_1), 64'd0);
      check({tag, "_e0_ram_addr"}, 64'(ram_addr_1), 64'd5);
      check({tag, "_e0_inst_bubble"}, inst_to_wb_1, 64'd0);
      bubble();
      step();
      check({tag, "_e1_stall"}, 64'(stall_req_1), 64'd1);
      check({tag, "_e1_ram_en"}, 64'(ram_en_1), 64'd0);
      step();
      check({tag, "_e2_stall"}, 64'(stall_req_1), 64'd1);
      check({tag, "_e2_pc_bubble"}, 64'(pc_to_wb_1), 64'd0);
      step();
      check({tag, "_e3_stall"}, 64'(stall_req_1), 64'd0);
      check({tag, "_e3_doutb"}, mem_doutb_1, 64'hDEADBEEF_00000000);
      check({tag, "_e3_u_rt"}, 64'(u_rt_to_wb_1), 64'd9);
      check({tag, "_e3_l_rt"}, 64'(l_rt_to_wb_1), 64'd3);
      check({tag, "_e3_pc"}, 64'(pc_to_wb_1), 64'h40);
      check({tag, "_e3_inst"}, inst_to_wb_1, 64'h8C090005_00432020);
   endtask

   initial begin
      rstn      = 1'b0;
      interlock = 1'b0;
      pre_we    = 1'b0;
      pre_sel   = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      bubble();
      preload(1'b0, 17'd5, 32'hDEADBEEF);
      preload(1'b0, 17'd1, 32'h0000000A);
      preload(1'b0, 17'd2, 32'h0000000B);
      preload(1'b1, 17'd0, 32'h55AA55AA);
      check("reset_stall", 64'(stall_req_1), 64'd0);
      check("reset_ram_en", 64'(ram_en_1), 64'd0);
      check("reset_pc", 64'(pc_to_wb_1), 64'd0);
      check("reset_inst", inst_to_wb_1, 64'd0);
      check("reset_doutb", mem_doutb_1, 64'd0);
      rstn = 1'b1;
      step();

      // Non-memory bundle passes straight through; interlock in IDLE freezes outputs.
      set_bundle(32'h10, ADD_INST, 32'd3, 32'd4, 32'd0, 32'd0, 5'd1, 5'd2);
      step();
      check("add_pc", 64'(pc_to_wb_1), 64'h10);
      check("add_inst", inst_to_wb_1, ADD_INST);
      check("add_u_rt", 64'(u_rt_to_wb_1), 64'd1);
      check("add_stall", 64'(stall_req_1), 64'd0);
      check("add_ram_en", 64'(ram_en_1), 64'd0);
      check("add_doutb", mem_doutb_1, 64'd0);
      interlock = 1'b1;
      set_bundle(32'h20, 64'h00851020_00000000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd7);
      step();
      check("hold_pc", 64'(pc_to_wb_1), 64'h10);
      check("hold_inst", inst_to_wb_1, ADD_INST);
      check("hold_stall", 64'(stall_req_1), 64'd0);
      interlock = 1'b0;
      step();
      check("release_pc", 64'(pc_to_wb_1), 64'h20);
      idle(2);

      load5_sequence("load5");
      idle(4);

      // Upper Store then lower Load to the same address.
      set_bundle(32'h80, {32'hAC080007, 32'h8C040007}, 32'd7, 32'd7, 32'h1234, 32'hFFFF, 5'd8, 5'd4);
      step();
      check("st_e0_ram_en", 64'(ram_en_1), 64'd1);
      check("st_e0_ram_we", 64'(ram_we_1), 64'd1);
      check("st_e0_ram_addr", 64'(ram_addr_1), 64'd7);
      check("st_e0_ram_din", 64'(ram_din_1), 64'h1234);
      bubble();
      step();
      check("st_e1_ram_en", 64'(ram_en_1), 64'd1);
      check("st_e1_ram_we", 64'(ram_we_1), 64'd0);
      check("st_e1_ram_addr", 64'(ram_addr_1), 64'd7);
      step();
      check("st_e2_ram_en", 64'(ram_en_1), 64'd0);
      check("st_e2_stall", 64'(stall_req_1), 64'd1);
      step();
      check("st_e3_stall", 64'(stall_req_1), 64'd1);
      check("st_e3_inst_bubble", inst_to_wb_1, 64'd0);
      step();
      check("st_e4_stall", 64'(stall_req_1), 64'd0);
      check("st_e4_doutb", mem_doutb_1, 64'h00000000_00001234);
      check("st_e4_l_rt", 64'(l_rt_to_wb_1), 64'd4);
      check("st_e4_pc", 64'(pc_to_wb_1), 64'h80);
      idle(4);

      // Dual Load with interlock raised during WAIT: result held in DONE.
      set_bundle(32'hC0, {32'h8C050001, 32'h8C060002}, 32'd1, 32'd2, 32'd0, 32'd0, 5'd5, 5'd6);
      step();
      bubble();
      step();
      check("dl_e1_ram_addr", 64'(ram_addr_1), 64'd2);
      step();
      interlock = 1'b1;
      step();
      check("dl_e3_stall", 64'(stall_req_1), 64'd1);
      step();
      check("dl_e4_done_stall", 64'(stall_req_1), 64'd1);
      check("dl_e4_done_inst", inst_to_wb_1, 64'd0);
      step();
      check("dl_e5_done_doutb", mem_doutb_1, 64'd0);
      interlock = 1'b0;
      step();
      check("dl_e6_doutb", mem_doutb_1, 64'h0000000A_0000000B);
      check("dl_e6_stall", 64'(stall_req_1), 64'd0);
      check("dl_e6_u_rt", 64'(u_rt_to_wb_1), 64'd5);
      check("dl_e6_l_rt", 64'(l_rt_to_wb_1), 64'd6);
      idle(4);

      // Reset in ISSUE_L drops the bundle; the next one works normally.
      set_bundle(32'hE0, {32'h8C050001, 32'h8C060002}, 32'd1, 32'd2, 32'd0, 32'd0, 5'd5, 5'd6);
      step();
      bubble();
      step();
      check("rst_pre_ram_en", 64'(ram_en_1), 64'd1);
      rstn = 1'b0;
      #1;
      check("rst_mid_ram_en", 64'(ram_en_1), 64'd0);
      check("rst_mid_stall", 64'(stall_req_1), 64'd0);
      check("rst_mid_pc", 64'(pc_to_wb_1), 64'd0);
      check("rst_mid_doutb", mem_doutb_1, 64'd0);
      #1;
      rstn = 1'b1;
      step();
      check("rst_after_stall", 64'(stall_req_1), 64'd0);
      check("rst_after_ram_en", 64'(ram_en_1), 64'd0);
      load5_sequence("post_rst");
      idle(4);

      // RAM_LAT=2 instance: address 0x20000 wraps to 0.
      set_bundle(32'h100, {32'h8C0A0000, 32'h00432020}, 32'h00020000, 32'd0, 32'd0, 32'd0, 5'd10, 5'd2);
      step();
      check("wrap_e0_ram_en", 64'(ram_en_2), 64'd1);
      check("wrap_e0_ram_addr", 64'(ram_addr_2), 64'd0);
      bubble();
      step();
      step();
      step();
      check("wrap_e3_stall", 64'(stall_req_2), 64'd1);
      check("wrap_e3_doutb", mem_doutb_2, 64'd0);
      step();
      check("wrap_e4_stall", 64'(stall_req_2), 64'd0);
      check("wrap_e4_doutb", mem_doutb_2, 64'h55AA55AA_00000000);
      check("wrap_e4_u_rt", 64'(u_rt_to_wb_2), 64'd10);
      check("wrap_e4_pc", 64'(pc_to_wb_2), 64'h100);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the dual-lane (upper/lower) pipeline, between exec and writeback.
- Takes one 64-bit bundle per accept from exec and serialises its Load/Store ops onto a single-ported 32-bit data BRAM, upper lane first.
- Presents pc, inst, lane rt fields and the packed 64-bit load data to writeback.
- Requests a pipeline stall while memory ops are in flight.

Parameters:
ADDR_W, 17, word-address width of the data BRAM
RAM_LAT, 1, BRAM read latency in cycles; 1 and 2 supported

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
interlock  in  1  global freeze from pipeline control
pc_from_exec  in  32  bundle pc
inst_from_exec  in  64  bundle; upper opcode [63:58], lower opcode [31:26]
u_addr_from_exec / l_addr_from_exec  in  32  word address per lane; low ADDR_W bits used
u_sdata_from_exec / l_sdata_from_exec  in  32  store data per lane
u_rt_from_exec / l_rt_from_exec  in  5  load destination per lane
ram_en / ram_we  out  1  BRAM enable / write enable, registered
ram_addr  out  ADDR_W  BRAM address, registered
ram_din  out  32  BRAM write data, registered
ram_dout  in  32  BRAM read data, valid RAM_LAT cycles after the request cycle
stall_req  out  1  registered; high while busy
pc_to_wb  out  32  to writeback
inst_to_wb  out  64  to writeback
u_rt_to_wb / l_rt_to_wb  out  5  to writeback
mem_doutb  out  64  packed load data: upper [63:32], lower [31:0]

Behaviour:
- Reset: all outputs 0; state IDLE; stall_req=0; ram_en=ram_we=0.
- Load and Store are nonzero opcodes from inst_package, so inst=0 is a bubble.
- A lane is a mem op iff its opcode is Load or Store.
- States: IDLE, ISSUE_U, ISSUE_L, WAIT, DONE.
- Accept: only in IDLE with interlock=0, on edge E0.
  - No mem op: outputs take the bundle at E0; mem_doutb=0; state stays IDLE. Throughput is 1 bundle/cycle.
  - Otherwise: latch the bundle; stall_req=1; outputs take a bubble (inst 0, rt 0, pc 0).
  - Next state: ISSUE_U if upper is a mem op, else ISSUE_L.
- ISSUE_U: drive the upper request during one cycle.
  - ram_en=1; ram_we = (Store); ram_addr = u_addr; ram_din = u_sdata.
  - Next: ISSUE_L if lower is a mem op, else WAIT.
- ISSUE_L: same for the lower lane; then WAIT.
- WAIT: counts RAM_LAT cycles after the last request, capturing ram_dout into the matching half on the edge where it is valid.
  - Store or non-mem halves are 0.
  - ram_en=0 outside ISSUE states.
- Completion edge, reached from WAIT:
  - interlock=0: outputs take the latched bundle and packed data; stall_req=0; go to IDLE.
  - interlock=1: go to DONE and hold the result; outputs stay bubble. Leave DONE on the first edge with interlock=0 and present the result then.
- Latency accept→outputs: 1 (no mem op); 2+RAM_LAT (one op); 3+RAM_LAT (two ops); plus interlock hold cycles.
- Interlock never suspends ISSUE or WAIT, so in-flight BRAM data is never lost.
- While interlock=1 in IDLE, outputs hold their value.
- Ordering: the upper access always precedes the lower. A lower Load to the same address as an upper Store returns the stored value.
- Addresses are truncated to ADDR_W bits with no bounds check, so they wrap.
- Reset mid-sequence: immediate return to IDLE, ram_en=0, outputs 0; the bundle is dropped.

Test Plan:
- Add-only bundle (pc=0x10) with interlock=0 → pc_to_wb=0x10 and inst copied at the next edge; stall_req never high; ram_en never high.
- Upper Load, addr 5 (RAM[5]=0xDEADBEEF), lower non-mem, RAM_LAT=1 → after 3 edges: mem_doutb=0xDEADBEEF_00000000, u_rt_to_wb=u_rt; stall_req high for 3 cycles.
- Upper Store 0x1234 to addr 7, lower Load from addr 7 → one write then one read; mem_doutb[31:0]=0x00001234; completion at accept+4.
- Dual Load, addresses 1 and 2 (values 0xA and 0xB), interlock raised at the WAIT cycle → DONE held; outputs stay bubble until interlock=0, then mem_doutb=0x0000000A_0000000B.
- rstn pulsed low during ISSUE_L → all outputs 0 and ram_en=0 immediately; the next bundle behaves normally.
- RAM_LAT=2 with an upper Load at addr 0x1FFFF+1 → access goes to addr 0 (wrap); completion at accept+4.
